// File: rtl/usb2_pkg.sv
// usb2_pkg: shared ULPI types and constants for the USB2 link
//   ulpi_state_t: ULPI bridge states; rx_event_t/rx_cmd_t: RX CMD fields
//   CMD_*: TX CMD prefixes; REG_*: ULPI register addresses
package usb2_pkg;
    typedef enum logic [3:0] {
        IDLE, TURN_RX, RX, TURN_TX, TX_DATA, TX_STP, REG_CMD, REG_DATA, REG_STP, ABORT
    } ulpi_state_t;
    typedef enum logic [1:0] {
        EV_NONE = 2'b00, EV_ACTIVE = 2'b01, EV_DISC = 2'b10, EV_ERR = 2'b11
    } rx_event_t;
    typedef struct packed {
        rx_event_t  ev;
        logic [1:0] vbus;
        logic [1:0] line;
    } rx_cmd_t;
    localparam logic [1:0] CMD_TX   = 2'b01;
    localparam logic [1:0] CMD_REGW = 2'b10;
    localparam logic [5:0] REG_FUNC_CTRL = 6'h04;
    localparam logic [5:0] REG_OTG_CTRL  = 6'h0A;
endpackage

// File: rtl/usb2_ulpi_rxcmd.sv
// usb2_ulpi_rxcmd: combinational RX CMD decode
//   data: low six bits of an RX CMD byte; cmd: line state, vbus state, RxEvent
module usb2_ulpi_rxcmd
    import usb2_pkg::*;
(
    input  logic [5:0] data,
    output rx_cmd_t    cmd
);
    assign cmd = rx_cmd_t'(data);
endmodule

// File: rtl/usb2_ulpi.sv
// usb2_ulpi: link-side ULPI 1.1 bridge between the PHY pins and the packet handler
//   phy_clk/reset: ULPI clock, sync active-high reset
//   ulpi_dir/nxt/data_in, ulpi_data_out/oe/stp: PHY bus
//   in_act/in_byte/in_latch: RX stream; out_byte/out_latch/out_stp/out_cts/out_nxt: TX stream
//   line_state/vbus_state/rx_err/host_disc/tx_abort: status
//   reg_wr/reg_addr/reg_data/reg_done/reg_fail: PHY register write
module usb2_ulpi
    import usb2_pkg::*;
#(
    parameter int TURN_CYC    = 1,
    parameter int REG_TIMEOUT = 255
) (
    input  logic       phy_clk,
    input  logic       reset,
    input  logic       ulpi_dir,
    input  logic       ulpi_nxt,
    input  logic [7:0] ulpi_data_in,
    output logic [7:0] ulpi_data_out,
    output logic       ulpi_data_oe,
    output logic       ulpi_stp,
    output logic       in_act,
    output logic [7:0] in_byte,
    output logic       in_latch,
    output logic       out_cts,
    output logic       out_nxt,
    input  logic [7:0] out_byte,
    input  logic       out_latch,
    input  logic       out_stp,
    output logic [1:0] line_state,
    output logic [1:0] vbus_state,
    output logic       rx_err,
    output logic       host_disc,
    output logic       tx_abort,
    input  logic       reg_wr,
    input  logic [5:0] reg_addr,
    input  logic [7:0] reg_data,
    output logic       reg_done,
    output logic       reg_fail
);
    ulpi_state_t state, state_nx;
    logic [15:0] cnt;
    logic        reg_pend;
    logic [5:0]  addr_q;
    logic [7:0]  data_q;
    rx_cmd_t     cmd;
    logic        rx_on, turn_done, timeout, reg_st, drive;

    usb2_ulpi_rxcmd u_rxcmd (.data(ulpi_data_in[5:0]), .cmd(cmd));

    assign rx_on     = (state == RX) && ulpi_dir;
    assign turn_done = cnt == 16'(TURN_CYC - 1);
    assign timeout   = cnt == 16'(REG_TIMEOUT - 1);
    assign reg_st    = state inside {REG_CMD, REG_DATA};

    // cnt measures time spent in the current state (turnaround and register timeout)
    always_ff @(posedge phy_clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= (state_nx != state) ? '0 : cnt + 16'd1;
        end
    end

    // A register request is remembered until IDLE gets to serve it
    always_ff @(posedge phy_clk) begin
        if (reset) begin
            reg_pend <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
        end else begin
            reg_pend <= (reg_pend | reg_wr) & ~((state == IDLE) && (state_nx == REG_CMD));
            if (reg_wr) begin
                addr_q <= reg_addr;
                data_q <= reg_data;
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     state_nx = ulpi_dir ? TURN_RX : out_latch ? TX_DATA : (reg_pend | reg_wr) ? REG_CMD : IDLE;
            TURN_RX:  state_nx = turn_done ? RX : TURN_RX;
            RX:       state_nx = ulpi_dir ? RX : TURN_TX;
            TURN_TX:  state_nx = turn_done ? IDLE : TURN_TX;
            TX_DATA:  state_nx = ulpi_dir ? ABORT : out_stp ? TX_STP : TX_DATA;
            TX_STP:   state_nx = IDLE;
            REG_CMD:  state_nx = ulpi_dir ? ABORT : ulpi_nxt ? REG_DATA : timeout ? IDLE : REG_CMD;
            REG_DATA: state_nx = ulpi_dir ? ABORT : ulpi_nxt ? REG_STP : timeout ? IDLE : REG_DATA;
            REG_STP:  state_nx = ulpi_dir ? ABORT : IDLE;
            ABORT:    state_nx = TURN_RX;
            default:  state_nx = IDLE;
        endcase
    end

    // The bus is released in the very cycle the PHY raises dir
    always_comb begin
        drive         = state inside {IDLE, TX_DATA, TX_STP, REG_CMD, REG_DATA, REG_STP};
        ulpi_data_oe  = drive & ~ulpi_dir & ~reset;
        ulpi_stp      = reset | ((state inside {TX_STP, REG_STP}) & ~ulpi_dir);
        ulpi_data_out = reset ? '0 : (state == TX_DATA) ? out_byte : (state == REG_CMD) ? {CMD_REGW, addr_q} :
                        (state == REG_DATA) ? data_q : '0;
        out_cts       = ~reset & (state == IDLE) & ~ulpi_dir & ~reg_pend;
        out_nxt       = ~reset & (state == TX_DATA) & ulpi_nxt & ~ulpi_dir;
        tx_abort      = ~reset & (state == TX_DATA) & ulpi_dir;
        reg_fail      = ~reset & ((reg_st & (ulpi_dir | (~ulpi_nxt & timeout))) | ((state == REG_STP) & ulpi_dir));
        reg_done      = ~reset & (state == REG_STP) & ~ulpi_dir;
    end

    always_ff @(posedge phy_clk) begin
        if (reset) begin
            in_act     <= 1'b0;
            in_byte    <= '0;
            in_latch   <= 1'b0;
            line_state <= '0;
            vbus_state <= '0;
            rx_err     <= 1'b0;
            host_disc  <= 1'b0;
        end else begin
            in_latch <= rx_on & ulpi_nxt;
            rx_err   <= rx_on & ~ulpi_nxt & (cmd.ev == EV_ERR);
            if (rx_on & ulpi_nxt) begin
                in_byte <= ulpi_data_in;
                in_act  <= 1'b1;
            end else if (rx_on) begin
                line_state <= cmd.line;
                vbus_state <= cmd.vbus;
                in_act     <= cmd.ev inside {EV_ACTIVE, EV_ERR};
                host_disc  <= cmd.ev == EV_DISC;
            end else if (state == RX) begin
                in_act <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_usb2_ulpi.sv
// tb_usb2_ulpi: self-checking bench for usb2_ulpi with a behavioural PHY/link model
module tb_usb2_ulpi;
    import usb2_pkg::*;

    logic       phy_clk = 1'b0;
    logic       reset = 1'b1;
    logic       ulpi_dir = 1'b0, ulpi_nxt = 1'b0;
    logic [7:0] ulpi_data_in = '0;
    logic [7:0] ulpi_data_out;
    logic       ulpi_data_oe, ulpi_stp;
    logic       in_act, in_latch, out_cts, out_nxt;
    logic [7:0] in_byte;
    logic [7:0] out_byte = '0;
    logic       out_latch = 1'b0, out_stp = 1'b0;
    logic [1:0] line_state, vbus_state;
    logic       rx_err, host_disc, tx_abort;
    logic       reg_wr = 1'b0;
    logic [5:0] reg_addr = '0;
    logic [7:0] reg_data = '0;
    logic       reg_done, reg_fail;

    int checks = 0;
    int failures = 0;
    logic [1:0] m_line = '0, m_vbus = '0;
    logic       m_act = 1'b0, m_disc = 1'b0;
    byte unsigned exp_q[$];
    byte unsigned got_q[$];

    usb2_ulpi dut (
        .phy_clk(phy_clk), .reset(reset), .ulpi_dir(ulpi_dir), .ulpi_nxt(ulpi_nxt),
        .ulpi_data_in(ulpi_data_in), .ulpi_data_out(ulpi_data_out), .ulpi_data_oe(ulpi_data_oe),
        .ulpi_stp(ulpi_stp), .in_act(in_act), .in_byte(in_byte), .in_latch(in_latch),
        .out_cts(out_cts), .out_nxt(out_nxt), .out_byte(out_byte), .out_latch(out_latch),
        .out_stp(out_stp), .line_state(line_state), .vbus_state(vbus_state), .rx_err(rx_err),
        .host_disc(host_disc), .tx_abort(tx_abort), .reg_wr(reg_wr), .reg_addr(reg_addr),
        .reg_data(reg_data), .reg_done(reg_done), .reg_fail(reg_fail)
    );

    always #8 phy_clk = ~phy_clk;

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge phy_clk);
        #1;
    endtask

    // PHY takes the bus; data during the n ignored cycles is an event-11 RX CMD that must not register
    task automatic rx_enter(int n);
        ulpi_dir = 1'b1;
        ulpi_nxt = 1'b0;
        ulpi_data_in = 8'hFF;
        #1;
        chk("rx_enter_oe", ulpi_data_oe, 0);
        chk("rx_enter_cts", out_cts, 0);
        repeat (n) tick;
        chk("turn_line", line_state, m_line);
        chk("turn_rx_err", rx_err, 0);
        chk("turn_act", in_act, m_act);
    endtask

    task automatic rx_step(logic nxt, logic [7:0] d);
        ulpi_nxt = nxt;
        ulpi_data_in = d;
        tick;
        if (nxt) begin
            exp_q.push_back(d);
            m_act = 1'b1;
        end else begin
            m_line = d[1:0];
            m_vbus = d[3:2];
            m_act  = (d[5:4] == 2'b01) || (d[5:4] == 2'b11);
            m_disc = d[5:4] == 2'b10;
        end
        if (in_latch) got_q.push_back(in_byte);
        chk("in_latch", in_latch, nxt);
        chk("in_act", in_act, m_act);
        chk("line_state", line_state, m_line);
        chk("vbus_state", vbus_state, m_vbus);
        chk("rx_err", rx_err, !nxt && (d[5:4] == 2'b11));
        chk("host_disc", host_disc, m_disc);
        if (nxt) chk("in_byte", in_byte, d);
    endtask

    task automatic rx_leave;
        ulpi_dir = 1'b0;
        ulpi_nxt = 1'b0;
        ulpi_data_in = '0;
        #1;
        chk("leave_oe", ulpi_data_oe, 0);
        tick;
        m_act = 1'b0;
        chk("leave_act", in_act, 0);
        chk("leave_latch", in_latch, 0);
        chk("turn_tx_oe", ulpi_data_oe, 0);
        tick;
        chk("idle_oe", ulpi_data_oe, 1);
        chk("idle_cts", out_cts, 1);
        chk("idle_dout", ulpi_data_out, 0);
    endtask

    task automatic tx_packet(logic [7:0] tx_cmd, int nbytes, int stall);
        byte unsigned q[$];
        int idx = 0;
        int guard = 0;
        q.push_back(tx_cmd);
        repeat (nbytes) q.push_back(8'($urandom));
        out_byte = q[0];
        out_latch = 1'b1;
        #1;
        chk("tx_cts_idle", out_cts, 1);
        tick;
        out_latch = 1'b0;
        while (idx < q.size() && guard < 200) begin
            out_byte = q[idx];
            ulpi_nxt = (guard >= stall) && ($urandom_range(0, 2) != 0);
            #1;
            chk("tx_data", ulpi_data_out, q[idx]);
            chk("tx_out_nxt", out_nxt, ulpi_nxt);
            chk("tx_oe", ulpi_data_oe, 1);
            chk("tx_cts", out_cts, 0);
            chk("tx_stp_low", ulpi_stp, 0);
            if (ulpi_nxt) idx++;
            tick;
            guard++;
        end
        chk("tx_all_sent", idx, q.size());
        ulpi_nxt = 1'b0;
        out_stp = 1'b1;
        tick;
        out_stp = 1'b0;
        chk("tx_stp", ulpi_stp, 1);
        chk("tx_stp_data", ulpi_data_out, 0);
        chk("tx_stp_oe", ulpi_data_oe, 1);
        tick;
        chk("tx_end_stp", ulpi_stp, 0);
        chk("tx_end_cts", out_cts, 1);
    endtask

    task automatic reg_write(logic [5:0] a, logic [7:0] d, int w1, int w2);
        reg_addr = a;
        reg_data = d;
        reg_wr = 1'b1;
        tick;
        reg_wr = 1'b0;
        for (int i = 0; i <= w1; i++) begin
            ulpi_nxt = (i == w1);
            #1;
            chk("reg_cmd_bus", ulpi_data_out, {2'b10, a});
            chk("reg_cmd_oe", ulpi_data_oe, 1);
            chk("reg_cmd_stp", ulpi_stp, 0);
            chk("reg_cmd_fail", reg_fail, 0);
            tick;
        end
        for (int i = 0; i <= w2; i++) begin
            ulpi_nxt = (i == w2);
            #1;
            chk("reg_data_bus", ulpi_data_out, d);
            chk("reg_data_done", reg_done, 0);
            tick;
        end
        ulpi_nxt = 1'b0;
        #1;
        chk("reg_stp", ulpi_stp, 1);
        chk("reg_done", reg_done, 1);
        chk("reg_stp_data", ulpi_data_out, 0);
        tick;
        chk("reg_done_once", reg_done, 0);
        chk("reg_end_stp", ulpi_stp, 0);
        chk("reg_end_cts", out_cts, 1);
    endtask

    initial begin
        int k;
        logic stp_seen;
        logic [7:0] rd;
        repeat (3) tick;
        chk("rst_oe", ulpi_data_oe, 0);
        chk("rst_stp", ulpi_stp, 1);
        chk("rst_cts", out_cts, 0);
        chk("rst_dout", ulpi_data_out, 0);
        chk("rst_act", in_act, 0);
        chk("rst_latch", in_latch, 0);
        chk("rst_byte", in_byte, 0);
        chk("rst_line", line_state, 0);
        chk("rst_disc", host_disc, 0);
        chk("rst_out_nxt", out_nxt, 0);
        reset = 1'b0;
        tick;
        chk("idle_oe", ulpi_data_oe, 1);
        chk("idle_stp", ulpi_stp, 0);
        chk("idle_cts", out_cts, 1);

        rx_enter(2);
        rx_step(1'b0, 8'h10);
        rx_step(1'b1, 8'h69);
        rx_step(1'b1, 8'h81);
        rx_step(1'b1, 8'h00);
        repeat (10) begin
            if ($urandom_range(0, 3) == 0) rx_step(1'b0, {2'b01, 4'($urandom)});
            else rx_step(1'b1, 8'($urandom));
        end
        rx_step(1'b0, {4'b0000, 4'($urandom)});
        rx_leave;
        chk("rx_count", got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) chk("rx_stream", got_q[i], exp_q[i]);

        tx_packet(8'h4D, 0, 3);
        tx_packet(8'h43, $urandom_range(2, 6), 0);

        reg_write(REG_FUNC_CTRL, 8'h45, 2, 2);
        reg_write(REG_OTG_CTRL, 8'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));

        rd = 8'($urandom);
        reg_addr = REG_OTG_CTRL;
        reg_data = rd;
        reg_wr = 1'b1;
        out_byte = 8'hC3;
        out_latch = 1'b1;
        tick;
        reg_wr = 1'b0;
        out_latch = 1'b0;
        chk("prio_tx", ulpi_data_out, 8'hC3);
        ulpi_nxt = 1'b1;
        tick;
        ulpi_nxt = 1'b0;
        out_stp = 1'b1;
        tick;
        out_stp = 1'b0;
        chk("prio_stp", ulpi_stp, 1);
        tick;
        chk("prio_pend_cts", out_cts, 0);
        tick;
        chk("prio_reg_cmd", ulpi_data_out, {2'b10, REG_OTG_CTRL});
        ulpi_nxt = 1'b1;
        tick;
        chk("prio_reg_data", ulpi_data_out, rd);
        tick;
        ulpi_nxt = 1'b0;
        #1;
        chk("prio_reg_done", reg_done, 1);
        tick;
        chk("prio_cts", out_cts, 1);

        out_byte = 8'($urandom);
        out_latch = 1'b1;
        tick;
        out_latch = 1'b0;
        #1;
        chk("abort_pre_oe", ulpi_data_oe, 1);
        ulpi_dir = 1'b1;
        ulpi_data_in = 8'hFF;
        #1;
        chk("abort_oe", ulpi_data_oe, 0);
        chk("abort_pulse", tx_abort, 1);
        chk("abort_no_stp", ulpi_stp, 0);
        tick;
        chk("abort_pulse_end", tx_abort, 0);
        chk("abort_no_stp2", ulpi_stp, 0);
        rx_enter(2);
        rx_step(1'b0, {2'b01, 4'($urandom)});
        rx_step(1'b1, 8'($urandom));
        rx_step(1'b0, {2'b11, 4'($urandom)});
        rx_step(1'b0, {2'b10, 4'($urandom)});

        ulpi_dir = 1'b0;
        ulpi_data_in = '0;
        tick;
        m_act = 1'b0;
        chk("b2b_act", in_act, 0);
        rx_enter(3);
        rx_step(1'b1, 8'($urandom));
        rx_step(1'b0, {4'b0000, 4'($urandom)});
        rx_leave;
        chk("rx_count2", got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) chk("rx_stream2", got_q[i], exp_q[i]);

        reg_addr = 6'($urandom);
        reg_wr = 1'b1;
        ulpi_nxt = 1'b0;
        tick;
        reg_wr = 1'b0;
        k = 1;
        stp_seen = 1'b0;
        while (!reg_fail && k < 400) begin
            stp_seen |= ulpi_stp;
            tick;
            k++;
        end
        chk("timeout_cycle", k, 255);
        chk("timeout_fail", reg_fail, 1);
        chk("timeout_no_stp", stp_seen | ulpi_stp, 0);
        tick;
        chk("timeout_fail_end", reg_fail, 0);
        chk("timeout_idle_cts", out_cts, 1);
        chk("timeout_idle_dout", ulpi_data_out, 0);

        out_byte = 8'($urandom);
        out_latch = 1'b1;
        tick;
        out_latch = 1'b0;
        reset = 1'b1;
        #1;
        chk("rst_tx_oe", ulpi_data_oe, 0);
        chk("rst_tx_stp", ulpi_stp, 1);
        chk("rst_tx_abort", tx_abort, 0);
        tick;
        chk("rst_tx_done", reg_done, 0);
        reset = 1'b0;
        tick;
        chk("post_rst_oe", ulpi_data_oe, 1);
        chk("post_rst_stp", ulpi_stp, 0);
        chk("post_rst_cts", out_cts, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
